// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: fetch FSM state enum, reset/halt address defaults, the nop word,
// and a small alignment helper used when redirect alignment checking is built in.
package mips_fetch_pkg;

  // RUN    : sequential fetch, no redirect outstanding
  // DELAY  : delay-slot instruction is in fetch, redirect target is pending
  // HALTED : parked at the halt address until reset
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DELAY  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // A word fetch address must have its two low bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mips_fetch_unit_counter.sv
// fetch_counter: 32-bit enable counter with synchronous active-low clear.
// Latency: count reflects an enabled edge one cycle later (registered).
// Backpressure: none; holds its value whenever en is low.
//
// Ports:
//   clk     in   clock, all updates on the rising edge
//   clear_n in   synchronous clear, 0 = load zero (wins over en)
//   en      in   increment this edge
//   count   out  current count, wraps FFFFFFFF -> 0
module fetch_counter (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch initiator: PC register, delay-slot redirect, halt on jump to HALT_ADDR.
// Latency: instr_address/instr/pc_plus4 are combinational from pc; pc/active/fault registered.
// Backpressure: stall freezes pc, FSM, pending target and counter; redirect is not sampled while stalled.
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets
// (sets sticky fault and halts immediately, no delay slot). Without it the low
// two target bits are cleared and fault is tied low.
//
// Ports:
//   clk              in   single clock
//   reset            in   synchronous active-low reset (0 = reset)
//   stall            in   hold all state this cycle
//   redirect_valid   in   taken branch/jump resolved for the instruction at pc
//   redirect_target  in   byte address of the taken target
//   instr_address    out  = pc, to instruction memory
//   instr_readdata   in   word from instruction memory (combinational)
//   instr            out  instr_readdata while active, else nop
//   pc               out  current fetch PC
//   pc_plus4         out  pc + 4 (link value)
//   active           out  core running
//   instr_count      out  fetches retired since reset
//   fault            out  misaligned redirect seen (align-check builds only)
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        active,
  output logic [31:0] instr_count,
  output logic        fault
);

  fetch_state_t state;
  logic [31:0]  pending_target;
  logic [31:0]  target_eff;
  logic         advance;

  // One fetch retires on every edge where the core runs and is not stalled.
  assign advance = active && !stall;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_eff = redirect_target;
  logic fault_q;
  assign fault = fault_q;
`else
  // Low bits are dropped so an odd target still lands on a word boundary.
  assign target_eff = redirect_target & ~32'h0000_0003;
  assign fault      = 1'b0;
`endif

  assign instr_address = pc;
  assign pc_plus4      = pc + PC_STEP;
  assign instr         = active ? instr_readdata : NOP_WORD;

  // Fetch FSM with registered pc / active / fault.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= RESET_VECTOR;
      state          <= ST_RUN;
      pending_target <= 32'd0;
      active         <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q        <= 1'b0;
`endif
    end else if (advance) begin
      case (state)
        ST_RUN: begin
          if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (is_misaligned(target_eff)) begin
              // Trap straight to the halt address; the delay slot is abandoned.
              fault_q <= 1'b1;
              state   <= ST_HALTED;
              pc      <= HALT_ADDR;
              active  <= 1'b0;
            end else begin
              pc             <= pc + PC_STEP;
              pending_target <= target_eff;
              state          <= ST_DELAY;
            end
`else
            pc             <= pc + PC_STEP;
            pending_target <= target_eff;
            state          <= ST_DELAY;
`endif
          end else begin
            pc <= pc + PC_STEP;
          end
        end
        ST_DELAY: begin
          // Delay slot retires now; a redirect presented here is ignored.
          pc <= pending_target;
          if (pending_target == HALT_ADDR) begin
            state  <= ST_HALTED;
            active <= 1'b0;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          pc     <= HALT_ADDR;
          state  <= ST_HALTED;
          active <= 1'b0;
        end
      endcase
    end else if (state != ST_HALTED) begin
      // First edge out of reset brings the core up; stalls keep it up.
      active <= 1'b1;
    end
  end

  fetch_counter u_counter (
    .clk     (clk),
    .clear_n (reset),
    .en      (advance),
    .count   (instr_count)
  );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        active;
  logic [31:0] instr_count;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: a distinctive word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  assign instr_readdata = mem_word(instr_address);

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .instr           (instr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .active          (active),
    .instr_count     (instr_count),
    .fault           (fault)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full observable state against expected pc / count / active.
  task automatic expect_state(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_cnt, input logic e_act);
    check_val({tag, ".pc"}, pc, e_pc);
    check_val({tag, ".addr"}, instr_address, e_pc);
    check_val({tag, ".cnt"}, instr_count, e_cnt);
    check_val({tag, ".act"}, {31'd0, active}, {31'd0, e_act});
    check_val({tag, ".instr"}, instr, e_act ? mem_word(e_pc) : 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    tick();
    tick();
    // Held in reset.
    expect_state("rst", 32'hBFC0_0000, 32'd0, 1'b0);
    check_val("rst.fault", {31'd0, fault}, 32'd0);
    check_val("rst.plus4", pc_plus4, 32'hBFC0_0004);

    // Release: first edge only raises active.
    reset = 1'b1;
    tick();
    expect_state("rel0", 32'hBFC0_0000, 32'd0, 1'b1);
    tick();
    expect_state("rel1", 32'hBFC0_0004, 32'd1, 1'b1);
    tick();
    expect_state("rel2", 32'hBFC0_0008, 32'd2, 1'b1);

    // Redirect at BFC00008 to BFC00100.
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0100;
    tick();
    expect_state("br.slot", 32'hBFC0_000C, 32'd3, 1'b1);
    redirect_valid = 1'b0;
    tick();
    expect_state("br.tgt", 32'hBFC0_0100, 32'd4, 1'b1);

    // Enter DELAY toward 12340000, then reset in the delay slot.
    redirect_valid  = 1'b1;
    redirect_target = 32'h1234_0000;
    tick();
    expect_state("dly", 32'hBFC0_0104, 32'd5, 1'b1);
    redirect_valid = 1'b0;
    reset          = 1'b0;
    tick();
    expect_state("dly.rst", 32'hBFC0_0000, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
    expect_state("dly.rel", 32'hBFC0_0000, 32'd0, 1'b1);
    tick();
    expect_state("dly.disc", 32'hBFC0_0004, 32'd1, 1'b1);

    // Stall three cycles with redirect held high.
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("stl%0d", i), 32'hBFC0_0004, 32'd1, 1'b1);
    end
    stall = 1'b0;
    tick();
    expect_state("stl.slot", 32'hBFC0_0008, 32'd2, 1'b1);
    redirect_valid = 1'b0;
    tick();
    expect_state("stl.tgt", 32'hBFC0_0200, 32'd3, 1'b1);

    // Redirect in the delay slot is ignored.
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0300;
    tick();
    expect_state("ign.slot", 32'hBFC0_0204, 32'd4, 1'b1);
    redirect_target = 32'hBFC0_0400;
    tick();
    expect_state("ign.tgt", 32'hBFC0_0300, 32'd5, 1'b1);
    redirect_valid = 1'b0;

    // Jump to zero: delay slot, then halt.
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    tick();
    expect_state("hlt.slot", 32'hBFC0_0304, 32'd6, 1'b1);
    redirect_valid = 1'b0;
    tick();
    expect_state("hlt", 32'h0, 32'd7, 1'b0);
    tick();
    tick();
    expect_state("hlt.hold", 32'h0, 32'd7, 1'b0);

    // pc arithmetic wraps silently at the top of the address space.
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    expect_state("wrap.top", 32'hFFFF_FFFC, 32'd2, 1'b1);
    check_val("wrap.plus4", pc_plus4, 32'h0);
    tick();
    expect_state("wrap.zero", 32'h0, 32'd3, 1'b1);

    // Misaligned redirect target.
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0102;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    expect_state("mis.trap", 32'h0, 32'd1, 1'b0);
    check_val("mis.fault", {31'd0, fault}, 32'd1);
    redirect_valid = 1'b0;
    tick();
    expect_state("mis.hold", 32'h0, 32'd1, 1'b0);
    check_val("mis.sticky", {31'd0, fault}, 32'd1);
`else
    expect_state("mis.slot", 32'hBFC0_0004, 32'd1, 1'b1);
    check_val("mis.fault", {31'd0, fault}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    expect_state("mis.tgt", 32'hBFC0_0100, 32'd2, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so a broken design can never hang the run.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch initiator for the MIPS core: holds the PC, drives a combinational instruction-memory read port, and presents the fetched word to decode. It implements the branch delay slot for redirects resolved by execute, and the halt-on-jump-to-zero convention: after the delay slot of a jump to 0x00000000 retires, `active` drops. It sits between the core's decode/execute logic and the `instr_address`/`instr_readdata` memory interface.

## Interface
- RESET_VECTOR, 32'hBFC00000, PC value loaded by reset.
- HALT_ADDR, 32'h00000000, redirect target that halts the core.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- stall  in  1  freeze PC/state/counter this cycle.
- redirect_valid  in  1  branch/jump taken, resolved for the instruction currently at `pc`.
- redirect_target  in  32  byte address of the taken target.
- instr_address  out  32  = `pc`, combinational.
- instr_readdata  in  32  word returned combinationally by instruction memory.
- instr  out  32  = `instr_readdata` while `active`, else 32'h0 (nop).
- pc  out  32  current fetch PC.
- pc_plus4  out  32  pc + 4 (link value source).
- active  out  1  core running.
- instr_count  out  32  fetches retired since reset.
- fault  out  1  misaligned redirect (only with FETCH_ALIGN_CHECK_EN; else tied 0).

## Operation
- States: RUN, DELAY (delay slot in fetch, target pending), HALTED.
- Reset (reset=0 at edge): pc=RESET_VECTOR, state=RUN, pending_target=0, instr_count=0, fault=0. `active`=0 while reset is asserted; 1 from the first edge with reset=1.
- Advance cycle = active && !stall. Non-advance cycles hold every register.
- RUN, advance: pc <= pc+4. If redirect_valid: pending_target <= redirect_target, state <= DELAY.
- DELAY, advance: pc <= pending_target. If pending_target==HALT_ADDR: state <= HALTED, else RUN. redirect_valid in DELAY is ignored (branch in delay slot unsupported).
- HALTED: pc holds HALT_ADDR, active=0, instr=0, counter frozen; only reset exits.
- instr_count += 1 on every advance cycle, including the delay slot; 32-bit wrap from FFFFFFFF to 0.
- pc arithmetic is 32-bit modulo; pc+4 wraps silently.
- stall and redirect_valid both high: redirect is not sampled; execute must hold redirect_valid until a non-stalled cycle.
- Reset mid-DELAY or in HALTED: state, pending target and counter are discarded and the reset values are reloaded.

## Timing
- instr_address, instr, pc_plus4: combinational from pc; zero latency to memory.
- Redirect seen at edge N (pc=B): edge N gives pc=B+4 (delay slot); edge N+1 gives pc=target.
- Halt: active falls after the edge that retires the delay slot of the jump to HALT_ADDR.
- fault: registered; asserts on the same edge as the misaligned redirect is sampled.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_target[1:0]!=0 sampled in RUN sets fault=1, and state goes straight to HALTED with pc=HALT_ADDR. No delay slot is executed. fault is sticky until reset.
- Undefined: redirect_target[1:0] is forced to 2'b00 and fault is constant 0.

## Structure
- Package mips_fetch_pkg holds the state enum (RUN/DELAY/HALTED), the RESET_VECTOR and HALT_ADDR defaults, and the NOP word constant.
- One sub-module, fetch_counter: a 32-bit enable counter with synchronous active-low clear, used for instr_count.

## Test plan
- Reset release, no stall, 3 cycles: pc = BFC00000 → BFC00004 → BFC00008; instr_count=2; active=1.
- Redirect at pc=BFC00008, target BFC00100: next pc=BFC0000C, then BFC00100; instr_count increments on both edges.
- Redirect to 0x0 at pc=BFC00010: delay slot BFC00014 fetched, then pc=0, active=0, instr=0; further cycles leave instr_count unchanged.
- stall=1 for 3 cycles with redirect_valid=1 at pc=BFC00004: pc and count hold. Stall releases with redirect still high: delay-slot sequence proceeds as normal.
- Reset asserted in DELAY state: pc=BFC00000, count=0, and the pending target is discarded (next pc=BFC00004).
- With FETCH_ALIGN_CHECK_EN, redirect target BFC00102: fault=1, HALTED, pc=0. Without the macro: delay slot executes, then pc=BFC00100.
